databus_arbiter_mc: RTL and testbench

//  Parametrised successor of the 4-register databus arbiter. Sits between the serial-to-parallel

---
 rtl/databus_arbiter_mc.sv | 256 +++++++++++++++++++++++++
 tb/tb_databus_arbiter_mc.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/databus_arbiter_mc.sv
// Databus arbiter: decodes front-end command frames into register loads, EEPROM
// program cycles, EEPROM reloads into the register bank and serial read-back.
// Every output is registered. Reload requests are single-cycle active-low pulses.
module databus_arbiter_mc #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned RD_CYCLES  = 4,
  parameter int unsigned CLR_CYCLES = 8,
  parameter int unsigned PGM_CYCLES = 16
) (
  input  logic                           sys_clk,
  input  logic                           porb,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           valid,
  input  logic                           por_pulseb,
  input  logic                           timeoutb,
  input  logic                           eep_loadb,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] eeprom_cache,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic [NUM_REGS-1:0]            reg_ldb,
  output logic                           read_eep,
  output logic                           pgm_eep,
  output logic                           eep_clrb,
  output logic                           eep_cycleb,
  output logic                           cache_out,
  output logic                           p2s_en,
  output logic                           busy,
  output logic                           err
);

  localparam int unsigned ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned MAX_A  = (RD_CYCLES > CLR_CYCLES) ? RD_CYCLES : CLR_CYCLES;
  localparam int unsigned MAX_B  = (PGM_CYCLES > DATA_WIDTH) ? PGM_CYCLES : DATA_WIDTH;
  localparam int unsigned MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W  = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0]  RD_LOAD    = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CLR_LOAD   = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  PGM_LOAD   = CNT_W'(PGM_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SHIFT_LOAD = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   NREGS_W    = NUM_REGS[ADDR_W:0];

  typedef enum logic [2:0] {
    StIdle, StData, StLoad, StRd, StReload, StClr, StPgm, StShift
  } state_t;

  state_t                         state_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [ADDR_W-1:0]              addr_q;
  logic [ADDR_W-1:0]              idx_q;
  logic                           phase_q;
  logic                           reload_q;
  logic                           pend_q;
  logic [DATA_WIDTH-1:0]          sr_q;
  logic [NUM_REGS*DATA_WIDTH-1:0] cache_q;

  logic [1:0]            cmd_op;
  logic [ADDR_W-1:0]     cmd_addr;
  logic                  addr_bad;
  logic                  reload_req;
  logic                  start_rl;
  logic [ADDR_W-1:0]     idx_nxt;
  logic [DATA_WIDTH-1:0] live_slice;
  logic [DATA_WIDTH-1:0] next_slice;

  // Select one DATA_WIDTH slice of a packed cache image.
  function automatic logic [DATA_WIDTH-1:0] pick(input logic [NUM_REGS*DATA_WIDTH-1:0] v,
                                                 input logic [ADDR_W-1:0] a);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a == ADDR_W'(i)) r = v[i*DATA_WIDTH +: DATA_WIDTH];
    end
    return r;
  endfunction

  // Command decode and slice selection.
  always_comb begin
    cmd_op     = data_in[DATA_WIDTH-1 -: 2];
    cmd_addr   = data_in[ADDR_W-1:0];
    addr_bad   = ({1'b0, cmd_addr} >= NREGS_W);
    reload_req = !por_pulseb || !eep_loadb;
    // Any reload source wins over an ordinary command word in IDLE.
    start_rl   = pend_q || reload_req || (valid && (cmd_op == 2'b11));
    idx_nxt    = idx_q + 1'b1;
    live_slice = pick(eeprom_cache, addr_q);
    next_slice = pick(cache_q, idx_nxt);
  end

  // Main FSM with registered outputs; strobes and err default inactive each cycle.
  always_ff @(posedge sys_clk or negedge porb) begin
    if (!porb) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      idx_q      <= '0;
      phase_q    <= 1'b0;
      reload_q   <= 1'b0;
      pend_q     <= 1'b0;
      sr_q       <= '0;
      cache_q    <= '0;
      data_out   <= '0;
      reg_ldb    <= '1;
      read_eep   <= 1'b0;
      pgm_eep    <= 1'b0;
      eep_clrb   <= 1'b1;
      eep_cycleb <= 1'b1;
      cache_out  <= 1'b0;
      p2s_en     <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      reg_ldb <= '1;
      err     <= 1'b0;
      if (state_q != StIdle && reload_req) pend_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (start_rl) begin
            pend_q   <= 1'b0;
            reload_q <= 1'b1;
            read_eep <= 1'b1;
            cnt_q    <= RD_LOAD;
            busy     <= 1'b1;
            state_q  <= StRd;
          end else if (valid) begin
            unique case (cmd_op)
              2'b00: begin
                if (addr_bad) begin
                  err <= 1'b1;
                end else begin
                  addr_q  <= cmd_addr;
                  busy    <= 1'b1;
                  state_q <= StData;
                end
              end
              2'b01: begin
                if (addr_bad) begin
                  err <= 1'b1;
                end else begin
                  addr_q   <= cmd_addr;
                  reload_q <= 1'b0;
                  read_eep <= 1'b1;
                  cnt_q    <= RD_LOAD;
                  busy     <= 1'b1;
                  state_q  <= StRd;
                end
              end
              default: begin
                eep_cycleb <= 1'b0;
                eep_clrb   <= 1'b0;
                cnt_q      <= CLR_LOAD;
                busy       <= 1'b1;
                state_q    <= StClr;
              end
            endcase
          end
        end

        StData: begin
          if (!timeoutb) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (valid) begin
            data_out <= data_in;
            state_q  <= StLoad;
          end
        end

        StLoad: begin
          reg_ldb[addr_q] <= 1'b0;
          busy            <= 1'b0;
          state_q         <= StIdle;
        end

        StRd: begin
          if (cnt_q == '0) begin
            read_eep <= 1'b0;
            cache_q  <= eeprom_cache;
            if (reload_q) begin
              data_out <= eeprom_cache[DATA_WIDTH-1:0];
              idx_q    <= '0;
              phase_q  <= 1'b0;
              state_q  <= StReload;
            end else begin
              cache_out <= live_slice[DATA_WIDTH-1];
              sr_q      <= {live_slice[DATA_WIDTH-2:0], 1'b0};
              p2s_en    <= 1'b1;
              cnt_q     <= SHIFT_LOAD;
              state_q   <= StShift;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        // Alternate cycles: data on the bus, then the strobe for that register.
        StReload: begin
          if (!phase_q) begin
            reg_ldb[idx_q] <= 1'b0;
            phase_q        <= 1'b1;
          end else if (idx_q == LAST_IDX) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            idx_q    <= idx_nxt;
            data_out <= next_slice;
            phase_q  <= 1'b0;
          end
        end

        StClr: begin
          if (cnt_q == '0) begin
            eep_clrb <= 1'b1;
            pgm_eep  <= 1'b1;
            cnt_q    <= PGM_LOAD;
            state_q  <= StPgm;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        StPgm: begin
          if (cnt_q == '0) begin
            pgm_eep    <= 1'b0;
            eep_cycleb <= 1'b1;
            busy       <= 1'b0;
            state_q    <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        StShift: begin
          if (!timeoutb || cnt_q == '0) begin
            p2s_en    <= 1'b0;
            cache_out <= 1'b0;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end else begin
            cache_out <= sr_q[DATA_WIDTH-1];
            sr_q      <= {sr_q[DATA_WIDTH-2:0], 1'b0};
            cnt_q     <= cnt_q - 1'b1;
          end
        end

        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_databus_arbiter_mc.sv
// Directed bench for databus_arbiter_mc: default instance plus a NUM_REGS=3
// instance for the illegal-address case.
module tb_databus_arbiter_mc;

  logic        sys_clk = 1'b0;
  logic        porb, valid, por_pulseb, timeoutb, eep_loadb;
  logic [7:0]  data_in;
  logic [31:0] eeprom_cache;
  logic [7:0]  data_out;
  logic [3:0]  reg_ldb;
  logic        read_eep, pgm_eep, eep_clrb, eep_cycleb, cache_out, p2s_en, busy, err;

  logic        valid3;
  logic [7:0]  data3;
  logic [7:0]  data_out3;
  logic [2:0]  reg_ldb3;
  logic        read_eep3, pgm_eep3, eep_clrb3, eep_cycleb3, cache_out3, p2s_en3, busy3, err3;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  databus_arbiter_mc u_dut (
    .sys_clk      (sys_clk),
    .porb         (porb),
    .data_in      (data_in),
    .valid        (valid),
    .por_pulseb   (por_pulseb),
    .timeoutb     (timeoutb),
    .eep_loadb    (eep_loadb),
    .eeprom_cache (eeprom_cache),
    .data_out     (data_out),
    .reg_ldb      (reg_ldb),
    .read_eep     (read_eep),
    .pgm_eep      (pgm_eep),
    .eep_clrb     (eep_clrb),
    .eep_cycleb   (eep_cycleb),
    .cache_out    (cache_out),
    .p2s_en       (p2s_en),
    .busy         (busy),
    .err          (err)
  );

  databus_arbiter_mc #(.NUM_REGS(3)) u_dut3 (
    .sys_clk      (sys_clk),
    .porb         (porb),
    .data_in      (data3),
    .valid        (valid3),
    .por_pulseb   (1'b1),
    .timeoutb     (1'b1),
    .eep_loadb    (1'b1),
    .eeprom_cache (eeprom_cache[23:0]),
    .data_out     (data_out3),
    .reg_ldb      (reg_ldb3),
    .read_eep     (read_eep3),
    .pgm_eep      (pgm_eep3),
    .eep_clrb     (eep_clrb3),
    .eep_cycleb   (eep_cycleb3),
    .cache_out    (cache_out3),
    .p2s_en       (p2s_en3),
    .busy         (busy3),
    .err          (err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    logic [3:0] strobe;
    int n;

    porb = 1'b0; valid = 1'b0; data_in = '0; por_pulseb = 1'b1; timeoutb = 1'b1;
    eep_loadb = 1'b1; eeprom_cache = 32'h44332211; valid3 = 1'b0; data3 = '0;
    repeat (3) step();

    chk("rst_data_out", data_out, 0);
    chk("rst_reg_ldb", reg_ldb, 4'hF);
    chk("rst_read_eep", read_eep, 0);
    chk("rst_pgm_eep", pgm_eep, 0);
    chk("rst_eep_clrb", eep_clrb, 1);
    chk("rst_eep_cycleb", eep_cycleb, 1);
    chk("rst_cache_out", cache_out, 0);
    chk("rst_p2s_en", p2s_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_reg_ldb3", reg_ldb3, 3'h7);
    porb = 1'b1;
    step();

    // Write 0xA5 to register 2.
    valid = 1'b1; data_in = 8'h02;
    step();
    chk("wr_busy_data", busy, 1);
    chk("wr_no_early_data", data_out, 0);
    data_in = 8'hA5;
    step();
    valid = 1'b0; data_in = '0;
    chk("wr_data_out", data_out, 8'hA5);
    chk("wr_no_early_strobe", reg_ldb, 4'hF);
    step();
    chk("wr_strobe", reg_ldb, 4'b1011);
    chk("wr_busy_done", busy, 0);
    step();
    chk("wr_strobe_release", reg_ldb, 4'hF);

    // POR reload of all four registers.
    por_pulseb = 1'b0;
    step();
    por_pulseb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rl_read_eep", read_eep, 1);
      chk("rl_rd_no_strobe", reg_ldb, 4'hF);
      step();
    end
    chk("rl_read_eep_off", read_eep, 0);
    for (int i = 0; i < 4; i++) begin
      pat = 8'h11 * 8'(i + 1);
      strobe = 4'hF;
      strobe[i] = 1'b0;
      chk("rl_data", data_out, pat);
      chk("rl_pre_strobe", reg_ldb, 4'hF);
      step();
      chk("rl_strobe", reg_ldb, strobe);
      chk("rl_data_hold", data_out, pat);
      step();
    end
    chk("rl_busy_done", busy, 0);
    chk("rl_strobe_release", reg_ldb, 4'hF);

    // Read back slice 1 = 0xC3.
    eeprom_cache = 32'h4433C311;
    valid = 1'b1; data_in = 8'h41;
    step();
    valid = 1'b0; data_in = '0;
    for (int i = 0; i < 4; i++) begin
      chk("rb_read_eep", read_eep, 1);
      chk("rb_p2s_idle", p2s_en, 0);
      step();
    end
    pat = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      chk("rb_p2s_en", p2s_en, 1);
      chk("rb_bit", cache_out, pat[i]);
      chk("rb_read_eep_off", read_eep, 0);
      step();
    end
    chk("rb_p2s_done", p2s_en, 0);
    chk("rb_busy_done", busy, 0);

    // Program, with an external reload request arriving during PGM.
    valid = 1'b1; data_in = 8'h80;
    step();
    valid = 1'b0; data_in = '0;
    for (int i = 0; i < 8; i++) begin
      chk("pg_clrb_low", eep_clrb, 0);
      chk("pg_cycleb_clr", eep_cycleb, 0);
      chk("pg_pgm_off", pgm_eep, 0);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      chk("pg_pgm_high", pgm_eep, 1);
      chk("pg_clrb_high", eep_clrb, 1);
      chk("pg_cycleb_pgm", eep_cycleb, 0);
      chk("pg_no_read", read_eep, 0);
      eep_loadb = (i == 2) ? 1'b0 : 1'b1;
      step();
    end
    eep_loadb = 1'b1;
    chk("pg_pgm_done", pgm_eep, 0);
    chk("pg_cycleb_done", eep_cycleb, 1);
    chk("pg_idle", busy, 0);
    chk("pg_no_early_read", read_eep, 0);
    step();
    chk("pend_read_eep", read_eep, 1);
    chk("pend_busy", busy, 1);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("pend_reload_done", busy, 0);
    chk("pend_last_data", data_out, 8'h44);

    // Illegal address on the 3-register instance.
    valid3 = 1'b1; data3 = 8'h03;
    step();
    valid3 = 1'b0; data3 = '0;
    chk("ill_wr_err", err3, 1);
    chk("ill_wr_no_strobe", reg_ldb3, 3'h7);
    chk("ill_wr_idle", busy3, 0);
    step();
    chk("ill_err_pulse", err3, 0);
    chk("ill_still_no_strobe", reg_ldb3, 3'h7);
    valid3 = 1'b1; data3 = 8'h43;
    step();
    valid3 = 1'b0; data3 = '0;
    chk("ill_rb_err", err3, 1);
    chk("ill_rb_idle", busy3, 0);
    step();
    chk("ill_rb_no_read", read_eep3, 0);

    // Abort a write in DATA.
    valid = 1'b1; data_in = 8'h00;
    step();
    valid = 1'b0;
    chk("to_data_busy", busy, 1);
    timeoutb = 1'b0;
    step();
    timeoutb = 1'b1;
    chk("to_data_idle", busy, 0);
    chk("to_data_no_strobe", reg_ldb, 4'hF);
    step();
    chk("to_data_no_late_strobe", reg_ldb, 4'hF);

    // Abort a read-back in SHIFT.
    valid = 1'b1; data_in = 8'h41;
    step();
    valid = 1'b0; data_in = '0;
    repeat (4) step();
    chk("to_shift_running", p2s_en, 1);
    step();
    step();
    timeoutb = 1'b0;
    step();
    timeoutb = 1'b1;
    chk("to_shift_p2s_off", p2s_en, 0);
    chk("to_shift_idle", busy, 0);

    // Asynchronous reset in the middle of PGM.
    valid = 1'b1; data_in = 8'h80;
    step();
    valid = 1'b0; data_in = '0;
    repeat (12) step();
    chk("ar_in_pgm", pgm_eep, 1);
    porb = 1'b0;
    #1;
    chk("ar_pgm_off", pgm_eep, 0);
    chk("ar_cycleb", eep_cycleb, 1);
    chk("ar_clrb", eep_clrb, 1);
    chk("ar_reg_ldb", reg_ldb, 4'hF);
    chk("ar_busy", busy, 0);
    chk("ar_data_out", data_out, 0);
    step();
    porb = 1'b1;
    step();
    step();
    chk("ar_stays_idle", busy, 0);
    chk("ar_stays_pgm_off", pgm_eep, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
